uart_cmd_decoder: RTL and testbench

//  Host-to-analyzer command path. Drains received bytes from the UART RX side
//  (rxempty/uld_rx_data handshake) and parses 1- or 2-byte commands.

---
 rtl/uart_cmd_decoder_if.sv | 9 +
 rtl/uart_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// UART RX unload handshake between the receive buffer (master) and the command decoder (slave).
interface uart_cmd_decoder_if;
  logic [7:0] rxdata;
  logic       rxempty;
  logic       uld_rx_data;

  modport master (output rxdata, output rxempty, input uld_rx_data);
  modport slave  (input rxdata, input rxempty, output uld_rx_data);
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses 1- and 2-byte host commands from the UART RX buffer into trigger mask,
// sample divider and one-cycle arm/status/error pulses.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [2:0]  MASK_DEFAULT   = 3'b111
) (
  input  logic                clk,
  input  logic                rst,
  uart_cmd_decoder_if.slave   uart,
  output logic [2:0]          triggerBlock_Mask,
  output logic [7:0]          sample_div,
  output logic                capture_arm,
  output logic                status_req,
  output logic                cmd_error,
  output logic [2:0]          state_debug
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] OP_MASK   = 8'h4D;
  localparam logic [7:0] OP_DIV    = 8'h44;
  localparam logic [7:0] OP_ARM    = 8'h52;
  localparam logic [7:0] OP_STATUS = 8'h3F;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    CAPT_OP   = 3'd2,
    WAIT_ARG  = 3'd3,
    FETCH_ARG = 3'd4,
    CAPT_ARG  = 3'd5,
    EXEC      = 3'd6,
    DRAIN     = 3'd7
  } state_t;

  state_t           state_r;
  logic [7:0]       op_r;
  logic [7:0]       arg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             empty_seen_r;
  logic             uld_r;
  logic [2:0]       mask_r;
  logic [7:0]       div_r;
  logic             arm_r;
  logic             status_r;
  logic             err_r;

  // Command FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      op_r         <= 8'h00;
      arg_r        <= 8'h00;
      cnt_r        <= {CNT_W{1'b0}};
      empty_seen_r <= 1'b0;
      uld_r        <= 1'b0;
      mask_r       <= MASK_DEFAULT;
      div_r        <= 8'h00;
      arm_r        <= 1'b0;
      status_r     <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      uld_r    <= 1'b0;
      arm_r    <= 1'b0;
      status_r <= 1'b0;
      err_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!uart.rxempty) begin
            state_r <= FETCH_OP;
            uld_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH_OP: state_r <= CAPT_OP;
        CAPT_OP: begin
          op_r <= uart.rxdata;
          case (uart.rxdata)
            OP_ARM, OP_STATUS: state_r <= EXEC;
            OP_MASK, OP_DIV: begin
              state_r      <= WAIT_ARG;
              cnt_r        <= {CNT_W{1'b0}};
              empty_seen_r <= 1'b0;
            end
            default: begin
              err_r   <= 1'b1;
              state_r <= DRAIN;
            end
          endcase
        end
        // The opcode byte must be seen gone (rxempty=1) before the next byte counts as the argument.
        WAIT_ARG: begin
          if (empty_seen_r && !uart.rxempty) begin
            state_r <= FETCH_ARG;
            uld_r   <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            err_r   <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            if (uart.rxempty) begin
              empty_seen_r <= 1'b1;
            end else begin
              empty_seen_r <= empty_seen_r;
            end
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CNT_ONE;
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        FETCH_ARG: state_r <= CAPT_ARG;
        CAPT_ARG: begin
          arg_r   <= uart.rxdata;
          state_r <= EXEC;
        end
        EXEC: begin
          case (op_r)
            OP_MASK:   mask_r   <= arg_r[2:0];
            OP_DIV:    div_r    <= arg_r;
            OP_ARM:    arm_r    <= 1'b1;
            OP_STATUS: status_r <= 1'b1;
            default:   err_r    <= 1'b1;
          endcase
          state_r <= DRAIN;
        end
        DRAIN: begin
          if (uart.rxempty) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign uart.uld_rx_data  = uld_r;
  assign triggerBlock_Mask = mask_r;
  assign sample_div        = div_r;
  assign capture_arm       = arm_r;
  assign status_req        = status_r;
  assign cmd_error         = err_r;
  assign state_debug       = state_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a task-driven UART RX model plus pulse monitors.
module tb_uart_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mask;
  logic [7:0] sdiv;
  logic       arm, status, err;
  logic [2:0] st;

  uart_cmd_decoder_if u_if ();

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16), .MASK_DEFAULT(3'b111)) dut (
    .clk               (clk),
    .rst               (rst),
    .uart              (u_if.slave),
    .triggerBlock_Mask (mask),
    .sample_div        (sdiv),
    .capture_arm       (arm),
    .status_req        (status),
    .cmd_error         (err),
    .state_debug       (st)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int uld_cnt = 0, arm_cnt = 0, status_cnt = 0, err_cnt = 0;
  int arm_cyc = 0, err_cyc = 0, wait_cyc = 0;
  logic [2:0] prev_st = 3'd0;
  int n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and state-entry monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (u_if.uld_rx_data) uld_cnt <= uld_cnt + 1;
    if (arm) begin arm_cnt <= arm_cnt + 1; arm_cyc <= cyc; end
    if (status) status_cnt <= status_cnt + 1;
    if (err) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
    if (st == 3'd3 && prev_st != 3'd3) wait_cyc <= cyc;
    prev_st <= st;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte; the buffer empties one edge after the unload pulse (later if hold>0).
  task automatic send_byte(input logic [7:0] b, input int hold, output int t0);
    logic got;
    @(negedge clk);
    u_if.rxdata  = b;
    u_if.rxempty = 1'b0;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (u_if.uld_rx_data) got = 1'b1;
    end
    check("uld_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    u_if.rxempty = 1'b1;
  endtask

  int t, u0, a0, e0, s0;

  initial begin
    rst = 1'b0;
    u_if.rxempty = 1'b1;
    u_if.rxdata  = 8'h00;
    idle(3);
    check("rst_mask", {29'd0, mask}, 32'd7);
    check("rst_sdiv", {24'd0, sdiv}, 32'd0);
    check("rst_state", {29'd0, st}, 32'd0);
    check("rst_uld", {31'd0, u_if.uld_rx_data}, 32'd0);
    rst = 1'b1;

    // Mask command
    u0 = uld_cnt;
    send_byte(8'h4D, 0, t);
    idle(2);
    check("m_mask_before", {29'd0, mask}, 32'd7);
    check("m_wait_state", {29'd0, st}, 32'd3);
    send_byte(8'h05, 0, t);
    idle(4);
    check("m_mask_after", {29'd0, mask}, 32'd5);
    check("m_uld_pulses", uld_cnt - u0, 32'd2);
    check("m_idle", {29'd0, st}, 32'd0);

    // Re-arm latency
    a0 = arm_cnt;
    send_byte(8'h52, 0, t);
    idle(4);
    check("r_arm_count", arm_cnt - a0, 32'd1);
    check("r_arm_latency", arm_cyc - t, 32'd4);
    check("r_mask_kept", {29'd0, mask}, 32'd5);

    // Argument timeout, then status
    e0 = err_cnt;
    send_byte(8'h44, 0, t);
    idle(25);
    check("to_err_count", err_cnt - e0, 32'd1);
    check("to_err_cycle", err_cyc - wait_cyc, 32'd16);
    check("to_sdiv_kept", {24'd0, sdiv}, 32'd0);
    check("to_idle", {29'd0, st}, 32'd0);
    s0 = status_cnt;
    send_byte(8'h3F, 0, t);
    idle(4);
    check("q_status", status_cnt - s0, 32'd1);
    check("q_no_err", err_cnt - e0, 32'd1);

    // Unknown opcode, then an argument that looks like an opcode
    e0 = err_cnt; a0 = arm_cnt;
    send_byte(8'h7A, 0, t);
    idle(4);
    check("u_err", err_cnt - e0, 32'd1);
    check("u_mask_kept", {29'd0, mask}, 32'd5);
    check("u_sdiv_kept", {24'd0, sdiv}, 32'd0);
    send_byte(8'h44, 0, t);
    idle(2);
    send_byte(8'h52, 0, t);
    idle(4);
    check("d_sdiv", {24'd0, sdiv}, 32'h52);
    check("d_no_arm", arm_cnt - a0, 32'd0);

    // Reset in the middle of a command
    send_byte(8'h4D, 0, t);
    idle(3);
    check("rr_wait_state", {29'd0, st}, 32'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_mask", {29'd0, mask}, 32'd7);
    check("rr_uld", {31'd0, u_if.uld_rx_data}, 32'd0);
    check("rr_state", {29'd0, st}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    e0 = err_cnt;
    send_byte(8'h05, 0, t);
    idle(4);
    check("rr_arg_as_op", err_cnt - e0, 32'd1);
    check("rr_mask_kept", {29'd0, mask}, 32'd7);

    // Stuck non-empty flag: no double unload
    u0 = uld_cnt; a0 = arm_cnt;
    send_byte(8'h52, 5, t);
    check("h_drain_state", {29'd0, st}, 32'd7);
    check("h_one_uld", uld_cnt - u0, 32'd1);
    idle(4);
    check("h_arm", arm_cnt - a0, 32'd1);
    check("h_idle", {29'd0, st}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
